// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes an asynchronous level and accepts a change
// only after STABLE_CYCLES consecutive equal synchronized samples.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add glitch_cnt_o,
// a saturating 8-bit count of rejected transitions.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_i,
    output logic       level_o,
    output logic       rise_o,
    output logic       fall_o
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,output logic [7:0] glitch_cnt_o
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit SINGLE_SAMPLE = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        CHECK_HI,
        STABLE_HI,
        CHECK_LO
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Synchronizer chain: shift the raw input in; only the last stage is used.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + CNT_ONE;

    // Debounce FSM: count equal samples after a change, accept or reject.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    if (SINGLE_SAMPLE) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = CHECK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHECK_HI: begin
                if (s) begin
                    if (cnt_inc == CNT_TARGET) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (SINGLE_SAMPLE) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = CHECK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHECK_LO: begin
                if (!s) begin
                    if (cnt_inc == CNT_TARGET) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Register synchronizer, FSM state, counter and the registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       reject;
    logic [7:0] glitch_q, glitch_d;

    assign reject = ((state_q == CHECK_HI) && !s) || ((state_q == CHECK_LO) && s);

    // Count rejected transitions, holding at 255 instead of wrapping.
    always_comb begin
        glitch_d = glitch_q;
        if (reject && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: scoreboard bench for debounce_sync. Instance u0 uses
// the default parameters, u1 uses SYNC_STAGES=3, STABLE_CYCLES=1.
// Glitch counter checks are active when DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_debounce_sync;

    typedef struct packed {
        logic rise;
        int   edge_n;
        logic level;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic d0 = 1'b0;
    logic d1 = 1'b0;
    logic level0, rise0, fall0;
    logic level1, rise1, fall1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch0, glitch1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int both_hi = 0;
    ev_t exp0[$], obs0[$], exp1[$], obs1[$];

    debounce_sync u0 (
        .clk(clk), .reset(reset), .d_i(d0),
        .level_o(level0), .rise_o(rise0), .fall_o(fall0)
`ifdef DEBOUNCE_GLITCH_CNT_EN
       ,.glitch_cnt_o(glitch0)
`endif
    );

    debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .d_i(d1),
        .level_o(level1), .rise_o(rise1), .fall_o(fall1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
       ,.glitch_cnt_o(glitch1)
`endif
    );

    // Free-running clock and a count of rising edges seen so far.
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // Record every output pulse, away from the active edge.
    always @(negedge clk) begin
        if (rise0 || fall0) obs0.push_back('{rise0, edge_cnt, level0});
        if (rise1 || fall1) obs1.push_back('{rise1, edge_cnt, level1});
        if ((rise0 && fall0) || (rise1 && fall1)) both_hi++;
    end

    // Hard stop if something hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; d0 = 1'b0; d1 = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({level0, rise0, fall0, level1, rise1, fall1} !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %b want 000000",
                     {level0, rise0, fall0, level1, rise1, fall1});
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch0 !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL reset_glitch: got %0d want 0", glitch0);
        end
`endif
        reset = 1'b1;
        tick();
    endtask

    task automatic test_rise();
        ev_t e, o;
        int  start;
        d0 = 1'b1;
        start = edge_cnt;
        exp0.push_back('{1'b1, start + 6, 1'b1});
        repeat (5) tick();
        n_cmp++;
        if (level0 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rise_early_level: got %b want 0", level0);
        end
        tick();
        n_cmp++;
        if ({level0, rise0} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL rise_edge6: got level/rise %b want 11", {level0, rise0});
        end
        for (int i = 0; i < 20 && obs0.size() == 0; i++) tick();
        n_cmp++;
        if (obs0.size() == 0) begin
            n_err++;
            $display("[TB] FAIL rise_event: got no pulse want rise at edge %0d", start + 6);
            void'(exp0.pop_front());
        end else begin
            e = exp0.pop_front();
            o = obs0.pop_front();
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL rise_event: got rise=%b edge=%0d level=%b want rise=%b edge=%0d level=%b",
                         o.rise, o.edge_n, o.level, e.rise, e.edge_n, e.level);
            end
        end
        tick();
        n_cmp++;
        if ({level0, rise0} !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL rise_edge7: got level/rise %b want 10", {level0, rise0});
        end
    endtask

    task automatic test_glitch();
        d0 = 1'b0;
        repeat (3) tick();
        d0 = 1'b1;
        repeat (12) begin
            tick();
            n_cmp++;
            if (level0 !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL glitch_level: got %b want 1", level0);
            end
        end
        n_cmp++;
        if (obs0.size() != 0) begin
            n_err++;
            $display("[TB] FAIL glitch_no_pulse: got %0d pulses want 0", obs0.size());
            obs0.delete();
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch0 !== 8'd1) begin
            n_err++;
            $display("[TB] FAIL glitch_count: got %0d want 1", glitch0);
        end
`endif
    endtask

    task automatic test_fall();
        ev_t e, o;
        int  start;
        d0 = 1'b0;
        start = edge_cnt;
        exp0.push_back('{1'b0, start + 6, 1'b0});
        repeat (5) tick();
        n_cmp++;
        if (level0 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL fall_early_level: got %b want 1", level0);
        end
        tick();
        n_cmp++;
        if ({level0, fall0} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL fall_edge6: got level/fall %b want 01", {level0, fall0});
        end
        for (int i = 0; i < 20 && obs0.size() == 0; i++) tick();
        n_cmp++;
        if (obs0.size() == 0) begin
            n_err++;
            $display("[TB] FAIL fall_event: got no pulse want fall at edge %0d", start + 6);
            void'(exp0.pop_front());
        end else begin
            e = exp0.pop_front();
            o = obs0.pop_front();
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL fall_event: got rise=%b edge=%0d level=%b want rise=%b edge=%0d level=%b",
                         o.rise, o.edge_n, o.level, e.rise, e.edge_n, e.level);
            end
        end
        tick();
        n_cmp++;
        if (fall0 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL fall_edge7: got %b want 0", fall0);
        end
    endtask

    task automatic test_short_pulses();
        for (int w = 1; w <= 3; w++) begin
            d0 = 1'b1;
            repeat (w) tick();
            d0 = 1'b0;
            repeat (6) begin
                tick();
                n_cmp++;
                if (level0 !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL short_pulse_level: width %0d got %b want 0", w, level0);
                end
            end
        end
        n_cmp++;
        if (obs0.size() != 0) begin
            n_err++;
            $display("[TB] FAIL short_pulse_no_pulse: got %0d pulses want 0", obs0.size());
            obs0.delete();
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch0 !== 8'd4) begin
            n_err++;
            $display("[TB] FAIL short_pulse_count: got %0d want 4", glitch0);
        end
`endif
    endtask

    task automatic test_reset_mid_check();
        d0 = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({level0, rise0, fall0} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL midcheck_reset_outputs: got %b want 000", {level0, rise0, fall0});
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch0 !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL midcheck_reset_glitch: got %0d want 0", glitch0);
        end
`endif
        d0 = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (12) tick();
        n_cmp++;
        if ((obs0.size() != 0) || (level0 !== 1'b0)) begin
            n_err++;
            $display("[TB] FAIL midcheck_after_release: got pulses=%0d level=%b want pulses=0 level=0",
                     obs0.size(), level0);
            obs0.delete();
        end
    endtask

    task automatic test_glitch_saturation();
`ifdef DEBOUNCE_GLITCH_CNT_EN
        for (int i = 0; i < 300; i++) begin
            d0 = 1'b1;
            repeat (2) tick();
            d0 = 1'b0;
            repeat (4) tick();
        end
        repeat (4) tick();
        n_cmp++;
        if (glitch0 !== 8'd255) begin
            n_err++;
            $display("[TB] FAIL glitch_saturate: got %0d want 255", glitch0);
        end
        n_cmp++;
        if ((level0 !== 1'b0) || (obs0.size() != 0)) begin
            n_err++;
            $display("[TB] FAIL glitch_saturate_level: got level=%b pulses=%0d want level=0 pulses=0",
                     level0, obs0.size());
            obs0.delete();
        end
`endif
    endtask

    task automatic test_release_high();
        ev_t e, o;
        int  start;
        reset = 1'b0;
        d0 = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        start = edge_cnt;
        exp0.push_back('{1'b1, start + 6, 1'b1});
        repeat (5) tick();
        n_cmp++;
        if (level0 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL release_early_level: got %b want 0", level0);
        end
        tick();
        n_cmp++;
        if ({level0, rise0} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL release_edge6: got level/rise %b want 11", {level0, rise0});
        end
        for (int i = 0; i < 20 && obs0.size() == 0; i++) tick();
        n_cmp++;
        if (obs0.size() == 0) begin
            n_err++;
            $display("[TB] FAIL release_event: got no pulse want rise at edge %0d", start + 6);
            void'(exp0.pop_front());
        end else begin
            e = exp0.pop_front();
            o = obs0.pop_front();
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL release_event: got rise=%b edge=%0d level=%b want rise=%b edge=%0d level=%b",
                         o.rise, o.edge_n, o.level, e.rise, e.edge_n, e.level);
            end
        end
    endtask

    task automatic test_fast_toggle();
        ev_t  e, o;
        logic newv;
        int   start;
        for (int k = 0; k < 6; k++) begin
            newv = ~d1;
            d1 = newv;
            start = edge_cnt;
            exp1.push_back('{newv, start + 4, newv});
            repeat (3) tick();
            n_cmp++;
            if (level1 !== ~newv) begin
                n_err++;
                $display("[TB] FAIL toggle_before: k=%0d got %b want %b", k, level1, ~newv);
            end
            tick();
            n_cmp++;
            if ({level1, rise1, fall1} !== {newv, newv, ~newv}) begin
                n_err++;
                $display("[TB] FAIL toggle_accept: k=%0d got level/rise/fall %b want %b",
                         k, {level1, rise1, fall1}, {newv, newv, ~newv});
            end
            tick();
            for (int i = 0; i < 20 && obs1.size() == 0; i++) tick();
            n_cmp++;
            if (obs1.size() == 0) begin
                n_err++;
                $display("[TB] FAIL toggle_event: k=%0d got no pulse want edge %0d", k, start + 4);
                void'(exp1.pop_front());
            end else begin
                e = exp1.pop_front();
                o = obs1.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("[TB] FAIL toggle_event: k=%0d got rise=%b edge=%0d level=%b want rise=%b edge=%0d level=%b",
                             k, o.rise, o.edge_n, o.level, e.rise, e.edge_n, e.level);
                end
            end
        end
        n_cmp++;
        if (obs1.size() != 0) begin
            n_err++;
            $display("[TB] FAIL toggle_extra: got %0d extra pulses want 0", obs1.size());
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (both_hi !== 0) begin
            n_err++;
            $display("[TB] FAIL rise_fall_exclusive: got %0d overlapping cycles want 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_short_pulses();
        test_reset_mid_check();
        test_glitch_saturation();
        test_release_high();
        test_fast_toggle();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on d_i; legal range 2..4.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, number of consecutive equal synchronized samples required to accept a level change; legal range 1..65535.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all flops are on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset; asserted when 0.
REQ-005 The block SHALL have port d_i, input, 1 bit, raw asynchronous level (switch or external DFF output).
REQ-006 The block SHALL have port level_o, output, 1 bit, debounced registered level.
REQ-007 The block SHALL have port rise_o, output, 1 bit, single-cycle pulse on an accepted 0->1 change of level_o.
REQ-008 The block SHALL have port fall_o, output, 1 bit, single-cycle pulse on an accepted 1->0 change of level_o.
REQ-009 The block SHALL have port glitch_cnt_o, output, 8 bits, count of rejected transitions; present only per REQ-026.

Function
REQ-010 The block SHALL pass d_i through a SYNC_STAGES-deep flop chain; the last stage is the sample s, and no logic SHALL read earlier stages.
REQ-011 The block SHALL implement a 4-state FSM: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
REQ-012 In STABLE_LO with s=1, the FSM SHALL go to CHECK_HI and load the counter with 1; with s=0 it SHALL stay.
REQ-013 In CHECK_HI with s=1, the counter SHALL increment; when the incremented value equals STABLE_CYCLES, the FSM SHALL go to STABLE_HI, set level_o=1 and pulse rise_o for exactly one cycle.
REQ-014 In CHECK_HI with s=0, the FSM SHALL return to STABLE_LO, clear the counter and leave level_o at 0 (a rejected transition).
REQ-015 STABLE_HI and CHECK_LO SHALL mirror REQ-012..014 with polarities swapped; fall_o pulses on acceptance.
REQ-016 With STABLE_CYCLES=1, acceptance SHALL occur on the first sample that differs, and the CHECK states SHALL never be occupied for more than zero cycles.
REQ-017 Latency: for d_i changed before edge 0 and held, level_o and the pulse SHALL update on rising edge number SYNC_STAGES+STABLE_CYCLES (counting edge 0 as 1).
REQ-018 The counter SHALL be $clog2(STABLE_CYCLES+1) bits wide and SHALL never wrap.
REQ-019 rise_o and fall_o SHALL never be high in the same cycle and SHALL be registered (no combinational path from d_i).
REQ-020 level_o SHALL change only on acceptance, so input pulses shorter than STABLE_CYCLES samples SHALL have no effect on level_o.

Reset
REQ-021 While reset=0, all synchronizer flops, the counter, level_o, rise_o, fall_o and glitch_cnt_o SHALL be 0 and the FSM SHALL be STABLE_LO, asynchronously.
REQ-022 Reset assertion mid-CHECK SHALL abandon the check without pulsing any output.
REQ-023 After release with d_i held high, the block SHALL debounce it as a normal rise per REQ-017 and pulse rise_o.

Configuration
REQ-024 Macro DEBOUNCE_GLITCH_CNT_EN SHALL control the rejected-transition counter.
REQ-025 Without the macro, glitch_cnt_o and its logic SHALL be absent.
REQ-026 With the macro, glitch_cnt_o SHALL exist and SHALL increment by 1 on every rejected transition (REQ-014 or mirror), saturating at 255.

Verification
REQ-027 Defaults; reset released, d_i=0->1 before edge 0 and held -> level_o=1 and rise_o=1 after edge 6; rise_o=0 after edge 7.
REQ-028 Defaults; level_o=1, d_i low for 3 cycles then high -> level_o stays 1, fall_o never pulses, glitch_cnt_o=1 (macro on).
REQ-029 Defaults; level_o=1, d_i 1->0 held -> fall_o single pulse and level_o=0 after the 6th edge following the change.
REQ-030 STABLE_CYCLES=1, SYNC_STAGES=3; d_i toggled every 5 cycles -> level_o follows d_i with 4-cycle delay; one pulse per toggle.
REQ-031 Reset asserted during CHECK_HI (2 samples in) -> all outputs 0 immediately; no rise_o after release while d_i=0.
REQ-032 Macro on; 300 glitches of 2 cycles -> glitch_cnt_o saturates at 255, level_o stays 0.
